// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame arbiter.
// Frame = header word + payload words + checksum word.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    OFFER
  } state_e;

  localparam int BPW_DEF = 8;
  localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

  function automatic int frame_words(input int nw);
    return nw + 2;
  endfunction

endpackage

// File: rtl/uart_frame_arbiter_if.sv
// Source-side and serializer-side handshake bundle.
// master = arbiter view, slave = producers/serializer view.
interface uart_frame_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int NUM_WORDS = 49,
  parameter int BITS_PER_WORD = BPW_DEF
);
  localparam int FW = frame_words(NUM_WORDS);

  logic [N_SRC-1:0] s_valid;
  logic [N_SRC-1:0] s_ready;
  logic [N_SRC-1:0][NUM_WORDS-1:0][BITS_PER_WORD-1:0] s_data;
  logic m_valid;
  logic m_ready;
  logic [FW-1:0][BITS_PER_WORD-1:0] m_data;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Search starts just after last_i and wraps around.
module rr_arbiter #(
  parameter int N_SRC = 2,
  parameter int ID_W = 1
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [N_SRC-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  int j;

  // first requester at or after last_i+1 wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      j = (int'(last_i) + k) % N_SRC;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Grants whole frames round-robin to one UART serializer,
// adding a source-ID header and a modular checksum word.
module uart_frame_arbiter
  import uart_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int NUM_WORDS = 49,
  parameter int BITS_PER_WORD = BPW_DEF,
  parameter logic [BITS_PER_WORD-1:0] HDR_BASE =
    BITS_PER_WORD'(HDR_BASE_DEF),
  localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  uart_frame_arbiter_if.master bus,
  output logic [ID_W-1:0] grant_id,
  output logic            busy
);

  localparam int FW = frame_words(NUM_WORDS);
  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef logic [BITS_PER_WORD-1:0] word_t;

  state_e state_q, state_d;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] pay_q, pay_d;
  logic [FW-1:0][BITS_PER_WORD-1:0] md_q, md_d;
  word_t acc_q, acc_d, acc_sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [ID_W-1:0] last_q, last_d;
  logic mv_q, mv_d;

  logic [N_SRC-1:0] gnt;
  logic [ID_W-1:0] idx;
  logic any;

  rr_arbiter #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_rr (
    .req_i  (bus.s_valid),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (idx),
    .any_o  (any)
  );

  // accept only while idle and out of reset
  assign bus.s_ready = (state_q == IDLE && rstn) ? gnt : '0;
  assign bus.m_valid = mv_q;
  assign bus.m_data = md_q;
  assign grant_id = gid_q;
  assign busy = (state_q != IDLE);
  assign acc_sum = acc_q + pay_q[cnt_q];

  // next-state: grant, accumulate checksum, offer frame
  always_comb begin
    state_d = state_q;
    pay_d = pay_q;
    md_d = md_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    gid_d = gid_q;
    last_d = last_q;
    mv_d = mv_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          pay_d = bus.s_data[idx];
          gid_d = idx;
          acc_d = HDR_BASE | word_t'(idx);
          cnt_d = '0;
          state_d = SUM;
        end
      end
      SUM: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NUM_WORDS - 1)) begin
          md_d[0] = HDR_BASE | word_t'(gid_q);
          for (int i = 0; i < NUM_WORDS; i++)
            md_d[i+1] = pay_q[i];
          md_d[FW-1] = acc_sum;
          mv_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (bus.m_ready) begin
          mv_d = 1'b0;
          last_d = gid_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pay_q <= '0;
      md_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      gid_q <= '0;
      last_q <= ID_W'(N_SRC - 1);
      mv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pay_q <= pay_d;
      md_q <= md_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      gid_q <= gid_d;
      last_q <= last_d;
      mv_q <= mv_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter.
// N_SRC=2, NUM_WORDS=4, 8-bit words, header A0.
module tb_uart_frame_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic grant_id;
  logic busy;
  int nerr = 0;
  int nchk = 0;
  int n;

  localparam logic [47:0] F0 = 48'hAA_04_03_02_01_A0;
  localparam logic [47:0] F1 = 48'h9D_FF_FF_FF_FF_A1;
  localparam logic [47:0] F8 = 48'hA0_80_80_80_80_A0;

  uart_frame_arbiter_if #(
    .N_SRC(2), .NUM_WORDS(4), .BITS_PER_WORD(8)
  ) bus ();

  uart_frame_arbiter #(
    .N_SRC(2), .NUM_WORDS(4), .BITS_PER_WORD(8),
    .HDR_BASE(8'hA0)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mv(output int cyc);
    cyc = 0;
    while (bus.m_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("mv_timeout", 64'(cyc < 40), 64'd1);
  endtask

  initial begin
    bus.s_valid = '0;
    bus.s_data = '0;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mv", 64'(bus.m_valid), 64'd0);
    chk("rst_md", 64'(bus.m_data), 64'd0);
    chk("rst_sr", 64'(bus.s_ready), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    rstn = 1'b1;

    // single frame from src0
    bus.s_data[0] = {8'h04, 8'h03, 8'h02, 8'h01};
    bus.s_valid = 2'b01;
    #1;
    chk("t1_sr", 64'(bus.s_ready), 64'd1);
    tick();
    bus.s_valid = 2'b00;
    #1;
    chk("t1_sr_busy", 64'(bus.s_ready), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_mv(n);
    chk("t1_lat", 64'(n), 64'd4);
    chk("t1_md", 64'(bus.m_data), 64'(F0));
    chk("t1_gid", 64'(grant_id), 64'd0);
    tick();
    chk("t1_mv_done", 64'(bus.m_valid), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // simultaneous requests after reset
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    bus.s_data[1] = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bus.s_valid = 2'b11;
    #1;
    chk("t2_sr0", 64'(bus.s_ready), 64'd1);
    tick();
    bus.s_valid = 2'b10;
    #1;
    chk("t2_sr_hold", 64'(bus.s_ready), 64'd0);
    wait_mv(n);
    chk("t2_md0", 64'(bus.m_data), 64'(F0));
    chk("t2_gid0", 64'(grant_id), 64'd0);
    chk("t2_sr_off", 64'(bus.s_ready), 64'd0);
    tick();
    #1;
    chk("t2_sr1", 64'(bus.s_ready), 64'd2);
    tick();
    bus.s_valid = 2'b00;
    wait_mv(n);
    chk("t2_md1", 64'(bus.m_data), 64'(F1));
    chk("t2_gid1", 64'(grant_id), 64'd1);
    tick();

    // continuous contention
    bus.s_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_mv(n);
      chk("t3_gid", 64'(grant_id), 64'(i % 2));
      chk("t3_hdr", 64'(bus.m_data[0]),
          64'(8'hA0 + 8'(i % 2)));
      if (i == 5) bus.s_valid = 2'b00;
      tick();
    end

    // backpressure and checksum wrap
    bus.s_data[0] = {8'h80, 8'h80, 8'h80, 8'h80};
    bus.m_ready = 1'b0;
    bus.s_valid = 2'b01;
    #1;
    chk("t4_sr", 64'(bus.s_ready), 64'd1);
    tick();
    bus.s_valid = 2'b10;
    wait_mv(n);
    chk("t4_md", 64'(bus.m_data), 64'(F8));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_mv_hold", 64'(bus.m_valid), 64'd1);
      chk("t4_md_hold", 64'(bus.m_data), 64'(F8));
      chk("t4_gid_hold", 64'(grant_id), 64'd0);
      chk("t4_sr_hold", 64'(bus.s_ready), 64'd0);
    end
    bus.s_valid = 2'b00;
    bus.m_ready = 1'b1;
    tick();
    chk("t4_mv_done", 64'(bus.m_valid), 64'd0);
    chk("t4_idle", 64'(busy), 64'd0);

    // reset in the middle of SUM
    bus.s_valid = 2'b11;
    #1;
    chk("t5_sr1", 64'(bus.s_ready), 64'd2);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    chk("t5_rst_mv", 64'(bus.m_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_sr", 64'(bus.s_ready), 64'd0);
    tick();
    rstn = 1'b1;
    #1;
    chk("t5_sr0", 64'(bus.s_ready), 64'd1);
    tick();
    bus.s_valid = 2'b00;
    wait_mv(n);
    chk("t5_gid", 64'(grant_id), 64'd0);
    chk("t5_md", 64'(bus.m_data), 64'(F8));
    tick();
    chk("t5_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_frame_arbiter.md
Name: uart_frame_arbiter

Overview:
- Shares the single UART transmitter (the AXI-Stream-to-UART serializer) between N_SRC image producers, for example the raw capture path and the salt-and-pepper filter output.
- Grants one whole image frame at a time, round-robin, and registers the payload.
- Adds a source-ID header byte and a mod-2^BITS_PER_WORD checksum byte.
- Presents the result as one wide word on a valid/ready master port that drives the serializer configured for NUM_WORDS+2 words.

Parameters:
- N_SRC, 2, number of requesting sources (2..8)
- NUM_WORDS, 49, payload words per frame (R_I*C_I*W_I/BITS_PER_WORD, 7x7x8 image)
- BITS_PER_WORD, 8, bits per UART word
- HDR_BASE, 8'hA0, header constant; low $clog2(N_SRC) bits must be 0
- ID_W, max(1,$clog2(N_SRC)), local, grant index width

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- s_valid  in  [N_SRC]  per-source frame valid
- s_data  in  [N_SRC][NUM_WORDS][BITS_PER_WORD]  per-source payload, word 0 sent first
- s_ready  out  [N_SRC]  per-source accept
- m_valid  out  1  framed word valid to serializer
- m_data  out  [NUM_WORDS+2][BITS_PER_WORD]  word0=header, words1..NUM_WORDS=payload, word NUM_WORDS+1=checksum
- m_ready  in  1  serializer ready (serializer in IDLE)
- grant_id  out  ID_W  source of frame currently held (valid when busy)
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - state=IDLE
  - m_valid=0, m_data=0, s_ready=0, grant_id=0, busy=0
  - checksum accumulator and word counter 0
  - last_grant=N_SRC-1, so source 0 has top priority after reset
- States:
  - IDLE: pick = first i with s_valid[i], searching from (last_grant+1) mod N_SRC upward with wrap. s_ready[pick] is combinationally 1 only in IDLE and only for pick; all other s_ready are 0. On s_valid[pick]: capture s_data[pick] into the payload register, set grant_id=pick, acc=HDR_BASE|pick, cnt=0, go to SUM. With no s_valid set, stay in IDLE.
  - SUM: each cycle acc += payload[cnt] (truncate to BITS_PER_WORD, carries dropped) and cnt++. At cnt==NUM_WORDS-1: build m_data with the final acc as checksum, set m_valid=1, go to OFFER. SUM lasts exactly NUM_WORDS cycles.
  - OFFER: hold m_valid=1 and m_data stable until m_valid&&m_ready. On that edge: m_valid=0, last_grant=grant_id, go to IDLE.
- Timing and handshake:
  - Latency: m_valid rises NUM_WORDS+1 cycles after the s_valid/s_ready handshake cycle.
  - No new grant while busy; throughput is at most one frame per (NUM_WORDS+2 + serializer time) cycles.
  - Sources must hold s_valid and s_data until accepted; the arbiter never drops a granted frame.
  - m_ready is ignored outside OFFER.
- Boundary conditions:
  - Fairness: with all sources continuously valid, grants rotate 0,1,..,N_SRC-1,0 with no starvation.
  - Single requester: that source is re-granted every frame.
  - s_valid rising in the same cycle the OFFER handshake completes is seen in the following IDLE cycle, after last_grant has been updated.
  - Reset mid-SUM or mid-OFFER aborts the frame: m_valid drops immediately and the priority pointer resets. The frame is not retransmitted; the source already saw it accepted.

Decomposition:
- Package uart_pkg holds:
  - the state enum {IDLE, SUM, OFFER}
  - BITS_PER_WORD default
  - HDR_BASE
  - a frame-word-count function (NUM_WORDS+2)
- One sub-module, rr_arbiter: combinational round-robin pick of N_SRC requests given last_grant. Outputs a one-hot grant and a binary index. The pointer register lives in the parent.

Test Plan:
All scenarios use N_SRC=2, NUM_WORDS=4, BITS_PER_WORD=8, HDR_BASE=A0.
- Single frame: src0 s_valid with bytes 01,02,03,04, m_ready=1 -> s_ready[0] high one cycle; m_valid rises 5 cycles later; m_data = {A0,01,02,03,04,AA}; grant_id=0; back to IDLE after the handshake.
- Simultaneous requests after reset: src0 and src1 both valid; src1 bytes FF,FF,FF,FF -> src0 frame first, then src1 frame with header A1, checksum (A1+3FC) mod 256 = 9D; s_ready[1] stays 0 until src0's OFFER completes.
- Continuous contention: both sources always valid for 6 frames -> grant order 0,1,0,1,0,1.
- Backpressure: m_ready=0 for 10 cycles in OFFER -> m_valid stays 1; m_data and grant_id unchanged; all s_ready=0. Then m_ready=1 -> one transfer, IDLE next cycle.
- Checksum wrap: src0 bytes 80,80,80,80 -> checksum (A0+200) mod 256 = A0.
- Reset mid-SUM: assert rstn=0 at the second SUM cycle -> m_valid=0, busy=0, s_ready=0 immediately. After release with both valid, src0 is granted first.
